// File: rtl/avalon_enforcer_pkg.sv
// Shared types and helpers for the Avalon-ST protocol enforcer.
package avalon_enforcer_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH_IN_BYTES = 16;

  // Width of the empty field; clamped to 1 so a 1-byte bus still has a legal vector.
  function automatic int empty_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int DEFAULT_EMPTY_WIDTH = empty_width(DEFAULT_DATA_WIDTH_IN_BYTES);

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: data, valid, sop, eop and empty travel downstream, rdy travels upstream.
interface avalon_st_if
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES
);
  localparam int EMPTY_WIDTH = empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_enforcer.sv
// Protocol guard: forwards only beats belonging to legal sop..eop packets, drains
// everything else and flags the two framing faults with registered one-cycle pulses.
module avalon_enforcer
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  avalon_st_if.slave  untrusted,
  avalon_st_if.master enforced,
  output logic       valid_out_of_packet,
  output logic       second_sop_indc
);
  localparam int EMPTY_WIDTH = empty_width(DATA_WIDTH_IN_BYTES);

  state_t state_reg, state_next;
  logic   voop_reg, voop_next;
  logic   sop2_reg, sop2_next;

  logic                   legal;
  logic                   accept;
  logic                   src_rdy;
  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [EMPTY_WIDTH-1:0] out_empty;

  // A beat is legal if it opens a packet from IDLE or lies inside an open packet.
  assign legal  = (state_reg == IN_PACKET) || untrusted.sop;
  assign accept = untrusted.valid && src_rdy;

  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    src_rdy   = 1'b1;
    if (legal) begin
      out_valid = untrusted.valid;
      out_sop   = (state_reg == IDLE) ? untrusted.sop : 1'b0;
      out_eop   = untrusted.eop;
      out_empty = untrusted.eop ? untrusted.empty : '0;
      src_rdy   = enforced.rdy;
    end
  end

  always_comb begin
    state_next = state_reg;
    voop_next  = 1'b0;
    sop2_next  = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!untrusted.sop) begin
            voop_next = 1'b1;
          end else if (!untrusted.eop) begin
            state_next = IN_PACKET;
          end
        end
        IN_PACKET: begin
          // A stray sop is flagged but does not restart the packet; eop still closes it.
          sop2_next = untrusted.sop;
          if (untrusted.eop) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      voop_reg  <= 1'b0;
      sop2_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      voop_reg  <= voop_next;
      sop2_reg  <= sop2_next;
    end
  end

  assign enforced.data  = untrusted.data;
  assign enforced.valid = out_valid;
  assign enforced.sop   = out_sop;
  assign enforced.eop   = out_eop;
  assign enforced.empty = out_empty;
  assign untrusted.rdy  = src_rdy;

  assign valid_out_of_packet = voop_reg;
  assign second_sop_indc     = sop2_reg;

endmodule

// File: tb/tb_avalon_enforcer.sv
// Bench for avalon_enforcer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a packet-level reference model.
module tb_avalon_enforcer;
  localparam int NB = 16;
  localparam int DW = 8 * NB;
  localparam int EW = $clog2(NB);

  logic clk;
  logic rst;
  logic valid_out_of_packet;
  logic second_sop_indc;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) src_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) snk_if ();

  avalon_enforcer #(.DATA_WIDTH_IN_BYTES(NB)) dut (
    .clk                (clk),
    .rst                (rst),
    .untrusted          (src_if.slave),
    .enforced           (snk_if.master),
    .valid_out_of_packet(valid_out_of_packet),
    .second_sop_indc    (second_sop_indc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: is a packet open, and which faults did the last accepted beat show.
  bit m_open;
  bit m_voop;
  bit m_sop2;

  function automatic bit beat_legal();
    return m_open || (src_if.sop === 1'b1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open <= 1'b0;
      m_voop <= 1'b0;
      m_sop2 <= 1'b0;
    end else begin
      bit lg, acc;
      lg  = beat_legal();
      acc = src_if.valid && (lg ? snk_if.rdy : 1'b1);
      m_voop <= acc && !lg;
      m_sop2 <= acc && m_open && src_if.sop;
      if (acc) begin
        if (m_open) m_open <= !src_if.eop;
        else        m_open <= src_if.sop && !src_if.eop;
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    bit lg;
    lg = beat_legal();
    chk("data", snk_if.data, src_if.data);
    chk("valid", DW'(snk_if.valid), DW'(lg ? src_if.valid : 1'b0));
    chk("sop", DW'(snk_if.sop), DW'(lg && !m_open ? src_if.sop : 1'b0));
    chk("eop", DW'(snk_if.eop), DW'(lg ? src_if.eop : 1'b0));
    chk("empty", DW'(snk_if.empty), DW'((lg && src_if.eop) ? src_if.empty : '0));
    chk("rdy", DW'(src_if.rdy), DW'(lg ? snk_if.rdy : 1'b1));
    chk("voop", DW'(valid_out_of_packet), DW'(m_voop));
    chk("sop2", DW'(second_sop_indc), DW'(m_sop2));
  end

  logic [DW-1:0] d22;

  task automatic drive(input bit v, input bit s, input bit e, input int emp,
                       input logic [DW-1:0] d, input bit erdy);
    @(posedge clk);
    #1;
    src_if.valid = v;
    src_if.sop   = s;
    src_if.eop   = e;
    src_if.empty = EW'(emp);
    src_if.data  = d;
    snk_if.rdy   = erdy;
    #2;
  endtask

  initial begin
    d22 = {NB{8'h22}};
    rst = 1'b1;
    src_if.valid = 1'b0; src_if.sop = 1'b0; src_if.eop = 1'b0;
    src_if.empty = '0;   src_if.data = '0;  snk_if.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_voop", DW'(valid_out_of_packet), '0);
    chk("reset_sop2", DW'(second_sop_indc), '0);
    rst = 1'b0;

    // Normal three-beat packet
    drive(1, 1, 0, 0, d22, 1);
    chk("pkt_sop", DW'(snk_if.sop), DW'(1));
    chk("pkt_valid", DW'(snk_if.valid), DW'(1));
    drive(1, 0, 0, 0, d22, 1);
    drive(1, 0, 1, 1, d22, 1);
    chk("pkt_eop", DW'(snk_if.eop), DW'(1));
    chk("pkt_empty", DW'(snk_if.empty), DW'(1));
    drive(0, 0, 0, 0, d22, 1);
    chk("pkt_no_ind", DW'({valid_out_of_packet, second_sop_indc}), '0);

    // Single-beat packet
    drive(1, 1, 1, 1, d22, 1);
    chk("single_sopeop", DW'({snk_if.sop, snk_if.eop, snk_if.valid}), DW'(3'b111));
    drive(0, 0, 0, 0, d22, 1);
    chk("single_no_ind", DW'({valid_out_of_packet, second_sop_indc}), '0);

    // Out-of-packet beat with a stalled sink: must still be drained
    drive(1, 0, 0, 3, d22, 0);
    chk("oop_valid", DW'(snk_if.valid), '0);
    chk("oop_rdy", DW'(src_if.rdy), DW'(1));
    chk("oop_empty", DW'(snk_if.empty), '0);
    drive(0, 0, 0, 0, d22, 1);
    chk("oop_pulse", DW'(valid_out_of_packet), DW'(1));
    drive(0, 0, 0, 0, d22, 1);
    chk("oop_pulse_end", DW'(valid_out_of_packet), '0);

    // Second sop inside a packet
    drive(1, 1, 0, 0, d22, 1);
    drive(1, 0, 0, 0, d22, 1);
    drive(1, 1, 0, 0, d22, 1);
    chk("sop2_forced0", DW'({snk_if.sop, snk_if.valid}), DW'(2'b01));
    drive(1, 0, 0, 0, d22, 1);
    chk("sop2_pulse", DW'(second_sop_indc), DW'(1));
    drive(1, 0, 1, 2, d22, 1);
    chk("sop2_pulse_end", DW'(second_sop_indc), '0);
    drive(1, 0, 0, 0, d22, 1);
    chk("after_eop_illegal", DW'(snk_if.valid), '0);

    // Back-pressure mid-packet
    drive(1, 1, 0, 0, d22, 1);
    drive(1, 0, 0, 0, d22, 0);
    chk("bp_rdy", DW'(src_if.rdy), '0);
    drive(1, 0, 0, 0, d22, 0);
    chk("bp_no_ind", DW'({valid_out_of_packet, second_sop_indc}), '0);
    chk("bp_valid", DW'(snk_if.valid), DW'(1));
    drive(1, 0, 0, 0, d22, 1);
    drive(1, 0, 1, 5, d22, 1);
    chk("bp_eop_empty", DW'(snk_if.empty), DW'(5));

    // Asynchronous reset between edges while an indicator is high
    drive(1, 1, 0, 0, d22, 1);
    drive(1, 1, 0, 0, d22, 1);
    drive(0, 0, 0, 0, d22, 1);
    chk("pre_rst_sop2", DW'(second_sop_indc), DW'(1));
    rst = 1'b1;
    #1;
    chk("rst_clears_sop2", DW'(second_sop_indc), '0);
    rst = 1'b0;
    drive(1, 0, 0, 0, d22, 1);
    chk("post_rst_illegal", DW'(snk_if.valid), '0);
    drive(0, 0, 0, 0, d22, 1);
    chk("post_rst_voop", DW'(valid_out_of_packet), DW'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 3), int'($urandom_range(0, NB - 1)),
            {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    drive(0, 0, 0, 0, d22, 1);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_enforcer.md
Name: avalon_enforcer

Overview:
- Protocol guard between an untrusted Avalon-ST source and a trusted downstream sink.
- Forwards only beats that form legal sop…eop packets. Drops or sanitises illegal beats.
- Raises one-cycle violation indicators for two faults: a valid beat outside a packet, and a second sop inside a packet.
- Sits at the ingress of any pipeline fed by an unverified producer.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes. Must equal the parameter of both connected avalon_st_if instances.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- untrusted  avalon_st_if.slave  bundle  source side.
  - Inputs: data[8*DATA_WIDTH_IN_BYTES], valid, sop, eop, empty[$clog2(DATA_WIDTH_IN_BYTES)].
  - Output: rdy.
- enforced  avalon_st_if.master  bundle  sink side.
  - Outputs: data, valid, sop, eop, empty.
  - Input: rdy.
- valid_out_of_packet  output  1  one-cycle pulse; a valid beat arrived while no packet was open.
- second_sop_indc  output  1  one-cycle pulse; sop arrived while a packet was already open.

Behaviour:
- Transfer: a beat is accepted on a rising edge when untrusted.valid && untrusted.rdy. Only accepted beats update state or indicators.
- State machine: IDLE, IN_PACKET. Reset state is IDLE.
- IDLE transitions:
  - Accepted beat with sop=1, eop=0 → IN_PACKET.
  - sop=1, eop=1 (single-beat packet) → stay IDLE.
  - sop=0 → stay IDLE; beat is illegal.
- IN_PACKET transitions:
  - Accepted beat with eop=1 → IDLE.
  - Otherwise stay IN_PACKET; a sop on that beat does not restart the packet.
- Datapath is combinational, zero added latency. enforced.data = untrusted.data in all cases.
- Legal beat (IDLE with sop=1, or IN_PACKET):
  - enforced.valid = untrusted.valid.
  - enforced.eop = untrusted.eop.
  - enforced.sop = untrusted.sop only when in IDLE; forced to 0 when in IN_PACKET.
  - enforced.empty = untrusted.empty when eop=1, else 0.
- Illegal beat (IDLE with sop=0): enforced.valid=0, sop=0, eop=0, empty=0. The beat is discarded.
- Back-pressure:
  - untrusted.rdy = enforced.rdy for legal beats.
  - untrusted.rdy = 1 for illegal beats, so a rogue source is drained and never stalls.
- valid_out_of_packet: registered. Asserted for exactly one cycle after an accepted illegal beat. Re-asserts for each consecutive illegal beat.
- second_sop_indc: registered. Asserted for exactly one cycle after an accepted beat in IN_PACKET with sop=1. This includes a sop+eop beat in IN_PACKET, which still closes the packet.
- valid=0 cycles never change state or indicators.
- Reset values: state IDLE, valid_out_of_packet=0, second_sop_indc=0.
  - While rst is high, enforced outputs follow IDLE rules.
  - Reset mid-packet abandons the packet; no eop is synthesised.
- The source must hold its beat until accepted; no internal buffering.

Decomposition:
- Shared package (e.g. avalon_enforcer_pkg) holds:
  - state enum {IDLE, IN_PACKET}.
  - localparam for empty width, $clog2(DATA_WIDTH_IN_BYTES).
- avalon_st_if is the existing codebase interface with modports master/slave, parameter DATA_WIDTH_IN_BYTES.
- Single module, no sub-modules. The FSM plus a combinational output mux is sufficient.

Test Plan:
- Normal packet: enforced.rdy=1; beats 0x22…22 sop=1 → plain → eop=1, empty=1.
  - Identical on enforced; state returns to IDLE.
  - Both indicators stay 0.
- Single-beat packet: sop=1, eop=1, empty=1, data 0x22….
  - Forwarded unchanged; state stays IDLE; no indicators.
- Valid out of packet: after a complete packet, one beat valid=1, sop=0.
  - enforced.valid=0 and untrusted.rdy=1.
  - valid_out_of_packet=1 for exactly the next cycle.
- Second sop: sop=1 beat, plain beat, beat with sop=1, plain beat, eop beat.
  - Third beat forwarded with enforced.sop=0; second_sop_indc pulses once.
  - Packet ends at the eop beat.
- Back-pressure: enforced.rdy=0 mid-packet.
  - untrusted.rdy=0; state holds; no indicator.
  - Resume with rdy=1 delivers the remaining beats in order.
- Async reset mid-packet: assert rst between edges.
  - Indicators clear immediately; state returns to IDLE.
  - A following non-sop beat is treated as out of packet.
